// File: rtl/matmul_pkg.sv
// Shared types, enum and output formatting for the streaming matrix multiplier.
// Build option: MATMUL_SATURATE_EN selects clamping instead of wrap in fmt_acc.
package matmul_pkg;

   localparam int MM_DATA_WIDTH = 16;
   localparam int MM_MAX_DIM    = 16;
   localparam int MM_ACC_WIDTH  = 2*MM_DATA_WIDTH + $clog2(MM_MAX_DIM);
   localparam int MM_DIM_WIDTH  = $clog2(MM_MAX_DIM+1);

   typedef logic signed [MM_DATA_WIDTH-1:0] element_t;
   typedef logic signed [MM_ACC_WIDTH-1:0]  acc_t;
   typedef logic        [MM_DIM_WIDTH-1:0]  dim_t;

   typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, MAC, EMIT} state_t;

   typedef struct packed {
      element_t data;
      logic     sat;
   } fmt_t;

`ifdef MATMUL_SATURATE_EN
   localparam element_t ELEM_MAX = {1'b0, {(MM_DATA_WIDTH-1){1'b1}}};
   localparam element_t ELEM_MIN = {1'b1, {(MM_DATA_WIDTH-1){1'b0}}};
`endif

   function automatic fmt_t fmt_acc(input acc_t a);
      fmt_t r;
      r.data = element_t'(a);
      r.sat  = 1'b0;
`ifdef MATMUL_SATURATE_EN
      if (a > acc_t'(ELEM_MAX)) begin
         r.data = ELEM_MAX;
         r.sat  = 1'b1;
      end else if (a < acc_t'(ELEM_MIN)) begin
         r.data = ELEM_MIN;
         r.sat  = 1'b1;
      end
`endif
      return r;
   endfunction

endpackage

// File: rtl/matmul_mac.sv
// Signed multiply-accumulate: one full-precision product per enabled cycle.
module matmul_mac #(
   parameter int DW = 16,
   parameter int AW = 36
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_en,
   input  logic                 i_clear,
   input  logic signed [DW-1:0] i_a,
   input  logic signed [DW-1:0] i_b,
   output logic signed [AW-1:0] o_acc
);

   logic signed [2*DW-1:0] w_prod;
   logic signed [AW-1:0]   r_acc;

   assign w_prod = i_a * i_b;

   // clear restarts the sum with this cycle's product rather than zero
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_acc <= '0;
      else if (i_en)
         r_acc <= i_clear ? AW'(w_prod) : r_acc + AW'(w_prod);
   end

   assign o_acc = r_acc;

endmodule

// File: rtl/matmul_stream.sv
// Runtime-sized streaming matrix multiplier C = A*B, one MAC per cycle.
// Build option: MATMUL_SATURATE_EN clamps results and adds the sat output.
module matmul_stream
   import matmul_pkg::*;
#(
   parameter int DATA_WIDTH = MM_DATA_WIDTH,
   parameter int MAX_DIM    = MM_MAX_DIM,
   parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(MAX_DIM)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          cfg_valid,
   output logic                          cfg_ready,
   input  logic [$clog2(MAX_DIM+1)-1:0]  cfg_n,
   input  logic [$clog2(MAX_DIM+1)-1:0]  cfg_m,
   input  logic [$clog2(MAX_DIM+1)-1:0]  cfg_q,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic signed [DATA_WIDTH-1:0]  in_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic signed [DATA_WIDTH-1:0]  out_data,
   output logic                          out_last,
   output logic                          busy,
   output logic                          err
`ifdef MATMUL_SATURATE_EN
   ,
   output logic                          sat
`endif
);

   localparam int ADDR_W = $clog2(MAX_DIM*MAX_DIM);

   state_t r_state, w_state_nxt;
   dim_t   r_n, r_m, r_q, r_i, r_j, r_k;
   logic   r_cfg_ready, r_in_ready, r_busy, r_err;
   logic   r_out_valid, r_out_last;
   element_t r_out_data;
`ifdef MATMUL_SATURATE_EN
   logic   r_sat;
`endif

   element_t r_a_mem [MAX_DIM*MAX_DIM];
   element_t r_b_mem [MAX_DIM*MAX_DIM];

   logic [ADDR_W-1:0]       w_a_addr, w_b_addr;
   logic                    w_cfg_ok, w_cfg_fire, w_in_fire, w_out_fire;
   logic                    w_i_end, w_j_end, w_k_end;
   logic signed [ACC_WIDTH-1:0] w_acc;

   assign w_cfg_ok = (cfg_n != '0) && (int'(cfg_n) <= MAX_DIM) &&
                     (cfg_m != '0) && (int'(cfg_m) <= MAX_DIM) &&
                     (cfg_q != '0) && (int'(cfg_q) <= MAX_DIM);
   assign w_cfg_fire = cfg_valid && r_cfg_ready;
   assign w_in_fire  = in_valid && r_in_ready;
   assign w_out_fire = r_out_valid && out_ready;
   assign w_i_end    = (r_i == r_n - dim_t'(1));
   assign w_j_end    = (r_j == r_q - dim_t'(1));
   assign w_k_end    = (r_k == r_m - dim_t'(1));

   // Same address serves the write during loading and the read during MAC
   assign w_a_addr = ADDR_W'(int'(r_i)*MAX_DIM + int'(r_k));
   assign w_b_addr = ADDR_W'(int'(r_k)*MAX_DIM + int'(r_j));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_state <= IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_cfg_fire && w_cfg_ok)        w_state_nxt = LOAD_A;
         LOAD_A:  if (w_in_fire && w_i_end && w_k_end) w_state_nxt = LOAD_B;
         LOAD_B:  if (w_in_fire && w_k_end && w_j_end) w_state_nxt = MAC;
         MAC:     if (w_k_end)                       w_state_nxt = EMIT;
         EMIT:    if (w_out_fire)                    w_state_nxt = r_out_last ? IDLE : MAC;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cfg_ready <= 1'b1;
         r_in_ready  <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_cfg_ready <= (w_state_nxt == IDLE);
         r_in_ready  <= (w_state_nxt == LOAD_A) || (w_state_nxt == LOAD_B);
         r_busy      <= (w_state_nxt != IDLE);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_n <= '0; r_m <= '0; r_q <= '0;
         r_i <= '0; r_j <= '0; r_k <= '0;
         r_err       <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_last  <= 1'b0;
`ifdef MATMUL_SATURATE_EN
         r_sat       <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: if (w_cfg_fire) begin
               if (w_cfg_ok) begin
                  r_err <= 1'b0;
                  r_n <= dim_t'(cfg_n); r_m <= dim_t'(cfg_m); r_q <= dim_t'(cfg_q);
                  r_i <= '0; r_j <= '0; r_k <= '0;
               end else begin
                  r_err <= 1'b1;
               end
            end
            LOAD_A: if (w_in_fire) begin
               if (w_k_end) begin
                  r_k <= '0;
                  r_i <= w_i_end ? '0 : r_i + dim_t'(1);
               end else begin
                  r_k <= r_k + dim_t'(1);
               end
            end
            LOAD_B: if (w_in_fire) begin
               if (w_j_end) begin
                  r_j <= '0;
                  r_k <= w_k_end ? '0 : r_k + dim_t'(1);
               end else begin
                  r_j <= r_j + dim_t'(1);
               end
            end
            MAC: r_k <= w_k_end ? '0 : r_k + dim_t'(1);
            // First EMIT cycle captures the settled accumulator; the rest wait for the handshake
            EMIT: if (!r_out_valid) begin
               r_out_valid <= 1'b1;
               r_out_data  <= fmt_acc(acc_t'(w_acc)).data;
               r_out_last  <= w_i_end && w_j_end;
`ifdef MATMUL_SATURATE_EN
               r_sat       <= fmt_acc(acc_t'(w_acc)).sat;
`endif
            end else if (out_ready) begin
               r_out_valid <= 1'b0;
               r_out_last  <= 1'b0;
               if (w_j_end) begin
                  r_j <= '0;
                  r_i <= r_i + dim_t'(1);
               end else begin
                  r_j <= r_j + dim_t'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_in_fire) begin
         if (r_state == LOAD_A)
            r_a_mem[w_a_addr] <= element_t'(in_data);
         else
            r_b_mem[w_b_addr] <= element_t'(in_data);
      end
   end

   matmul_mac #(
      .DW (DATA_WIDTH),
      .AW (ACC_WIDTH)
   ) u_mac (
      .i_clk   (clk),
      .i_rst_n (reset),
      .i_en    (r_state == MAC),
      .i_clear (r_k == '0),
      .i_a     (r_a_mem[w_a_addr]),
      .i_b     (r_b_mem[w_b_addr]),
      .o_acc   (w_acc)
   );

   assign cfg_ready = r_cfg_ready;
   assign in_ready  = r_in_ready;
   assign busy      = r_busy;
   assign err       = r_err;
   assign out_valid = r_out_valid;
   assign out_data  = DATA_WIDTH'(r_out_data);
   assign out_last  = r_out_last;
`ifdef MATMUL_SATURATE_EN
   assign sat       = r_sat;
`endif

endmodule

// File: tb/tb_matmul_stream.sv
// Self-checking bench for matmul_stream against a plain-arithmetic matrix model.
// Honours MATMUL_SATURATE_EN (expects clamping and checks sat when defined).
module tb_matmul_stream;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               cfg_valid, cfg_ready;
   logic [4:0]         cfg_n, cfg_m, cfg_q;
   logic               in_valid, in_ready;
   logic signed [15:0] in_data;
   logic               out_valid, out_ready, out_last;
   logic signed [15:0] out_data;
   logic               busy, err;
`ifdef MATMUL_SATURATE_EN
   logic               sat;
`endif

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;
   int a_q[$];
   int b_q[$];

   matmul_stream u_dut (
      .clk       (clk),
      .reset     (rst_n),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_n     (cfg_n),
      .cfg_m     (cfg_m),
      .cfg_q     (cfg_q),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .busy      (busy),
      .err       (err)
`ifdef MATMUL_SATURATE_EN
      ,
      .sat       (sat)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input longint obs, input longint exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic longint fmt_model(input longint s);
`ifdef MATMUL_SATURATE_EN
      if (s > 32767)  return 32767;
      if (s < -32768) return -32768;
      return s;
`else
      longint w;
      w = s & 64'hFFFF;
      if (w >= 32768) w -= 65536;
      return w;
`endif
   endfunction

   task automatic send_cfg(input int n, input int m, input int q);
      int g = 0;
      @(negedge clk);
      while (!cfg_ready && g < 2000) begin
         @(negedge clk);
         g++;
      end
      check_val("cfg_ready_wait", cfg_ready, 1);
      cfg_valid = 1'b1;
      cfg_n = 5'(n); cfg_m = 5'(m); cfg_q = 5'(q);
      @(negedge clk);
      cfg_valid = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_cfg_ready"}, cfg_ready, 1);
      check_val({tag, "_in_ready"},  in_ready,  0);
      check_val({tag, "_out_valid"}, out_valid, 0);
      check_val({tag, "_out_data"},  out_data,  0);
      check_val({tag, "_out_last"},  out_last,  0);
      check_val({tag, "_busy"},      busy,      0);
      check_val({tag, "_err"},       err,       0);
   endtask

   task automatic run_job(input int n, input int m, input int q,
                          input bit gaps, input bit bp, input bit stall_first);
      longint expq[$];
      longint s;
      int all[$];
      int k, idx, t_lastb, t_ref, stalls, g;
      bit seen;
      for (int i = 0; i < n; i++)
         for (int j = 0; j < q; j++) begin
            s = 0;
            for (int kk = 0; kk < m; kk++)
               s += longint'(a_q[i*m+kk]) * longint'(b_q[kk*q+j]);
            expq.push_back(s);
         end

      send_cfg(n, m, q);
      check_val("cfg_busy", busy, 1);
      check_val("cfg_err_clear", err, 0);
      check_val("cfg_ready_low", cfg_ready, 0);

      all = {a_q, b_q};
      k = 0; g = 0; t_lastb = 0;
      while (k < all.size() && g < 20000) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
         end else begin
            in_valid = 1'b1;
            in_data  = 16'(all[k]);
         end
         if (in_valid && in_ready) begin
            if (k == all.size() - 1) t_lastb = cyc + 1;
            k++;
         end
         @(negedge clk);
         g++;
      end
      in_valid = 1'b0;
      check_val("load_count", k, all.size());
      check_val("in_ready_after_load", in_ready, 0);

      idx = 0; seen = 1'b0; t_ref = t_lastb; stalls = 0; g = 0;
      while (idx < n*q && g < 40000) begin
         out_ready = !(stall_first && idx == 0 && stalls < 5) &&
                     !(bp && $urandom_range(0, 2) == 0);
         if (out_valid) begin
            if (!seen) begin
               check_val("latency", cyc - t_ref, m + 1);
               seen = 1'b1;
            end
            check_val("data", out_data, fmt_model(expq[idx]));
            check_val("last", out_last, (idx == n*q - 1) ? 1 : 0);
`ifdef MATMUL_SATURATE_EN
            check_val("sat", sat, (fmt_model(expq[idx]) != expq[idx]) ? 1 : 0);
`endif
            if (out_ready) begin
               t_ref = cyc + 1;
               idx++;
               seen = 1'b0;
            end else begin
               stalls++;
            end
         end
         @(negedge clk);
         g++;
      end
      out_ready = 1'b0;
      check_val("out_count", idx, n*q);
      check_val("done_cfg_ready", cfg_ready, 1);
      check_val("done_busy", busy, 0);
      check_val("done_out_valid", out_valid, 0);
   endtask

   task automatic fill_random(input int n, input int m, input int q);
      a_q.delete();
      b_q.delete();
      for (int e = 0; e < n*m; e++) a_q.push_back(int'(shortint'($urandom)));
      for (int e = 0; e < m*q; e++) b_q.push_back(int'(shortint'($urandom)));
   endtask

   initial begin
      rst_n = 1'b0;
      cfg_valid = 1'b0; cfg_n = '0; cfg_m = '0; cfg_q = '0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk);

      a_q = '{3}; b_q = '{-2};
      run_job(1, 1, 1, 1'b0, 1'b0, 1'b0);

      a_q = '{1, 2, 3, 4}; b_q = '{5, 6, 7, 8};
      run_job(2, 2, 2, 1'b0, 1'b0, 1'b1);

      a_q = '{1, 0, 2, 0, 1, 1}; b_q = '{1, 2, 3, 4, 5, 6};
      run_job(2, 3, 2, 1'b1, 1'b1, 1'b0);

      // rejected descriptors: zero and oversize dimensions
      send_cfg(0, 2, 2);
      check_val("rej0_err", err, 1);
      check_val("rej0_busy", busy, 0);
      check_val("rej0_cfg_ready", cfg_ready, 1);
      in_valid = 1'b1; in_data = 16'sd7;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check_val("rej0_in_ready", in_ready, 0);
      end
      in_valid = 1'b0;
      send_cfg(2, 2, 17);
      check_val("rej17_err", err, 1);
      check_val("rej17_busy", busy, 0);
      @(negedge clk);
      check_val("rej17_in_ready", in_ready, 0);
      a_q = '{-5}; b_q = '{9};
      run_job(1, 1, 1, 1'b0, 1'b0, 1'b0);

      a_q = '{32767, 32767}; b_q = '{2, 2};
      run_job(1, 2, 1, 1'b0, 1'b0, 1'b0);

      a_q = '{-32768, -32768}; b_q = '{2, 2};
      run_job(1, 2, 1, 1'b0, 1'b0, 1'b0);

      // reset asserted while B is half loaded
      send_cfg(2, 2, 2);
      for (int e = 0; e < 6; e++) begin
         in_valid = 1'b1;
         in_data  = 16'(e + 1);
         @(negedge clk);
      end
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midjob_reset");
      @(negedge clk);
      rst_n = 1'b1;
      a_q = '{2, -1, 4, 3}; b_q = '{-7, 1, 6, 5};
      run_job(2, 2, 2, 1'b0, 1'b0, 1'b0);

      for (int t = 0; t < 6; t++) begin
         int n, m, q;
         n = $urandom_range(1, 4);
         m = $urandom_range(1, 4);
         q = $urandom_range(1, 4);
         fill_random(n, m, q);
         run_job(n, m, q, 1'b1, 1'b1, 1'b0);
      end

      fill_random(16, 16, 16);
      run_job(16, 16, 16, 1'b0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/matmul_stream.md
Name: matmul_stream

Overview:
- Runtime-sized signed matrix multiplier: C[n×q] = A[n×m] · B[m×q], with n, m and q set per job.
- A and B stream in over one valid/ready port into internal buffers; C streams out row-major on a second port.
- One MAC per cycle; successor to the fixed-size matmul datapath, exercised by the matrix testbench.

Parameters:
- DATA_WIDTH, 16, signed element width for A, B and C.
- MAX_DIM, 16, maximum of each of n, m, q; buffer depth is MAX_DIM*MAX_DIM per operand.
- ACC_WIDTH, 2*DATA_WIDTH+$clog2(MAX_DIM), signed accumulator width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cfg_valid  in  1  job descriptor valid.
- cfg_ready  out  1  block idle, can accept a descriptor.
- cfg_n / cfg_m / cfg_q  in  $clog2(MAX_DIM+1) each  job dimensions.
- in_valid  in  1  operand element valid.
- in_ready  out  1  block accepts operand element.
- in_data  in  DATA_WIDTH  operand element: A row-major, then B row-major.
- out_valid  out  1  C element valid.
- out_ready  in  1  downstream accepts C element.
- out_data  out  DATA_WIDTH  C element, row-major.
- out_last  out  1  marks C[n-1][q-1].
- busy  out  1  high in every state except IDLE.
- err  out  1  sticky: last descriptor rejected.

Behaviour:
- Reset values: cfg_ready=1, in_ready=0, out_valid=0, out_data=0, out_last=0, busy=0, err=0; FSM=IDLE.
- Reset mid-job aborts immediately to IDLE. Buffer contents are don't-care.
- Handshakes: a transfer occurs when valid&&ready on a rising edge. Signals from the block are registered. out_data/out_last hold stable while out_valid=1 && out_ready=0.
- FSM:
  - IDLE: cfg_ready=1. On cfg handshake:
    - Any dimension equal to 0 or greater than MAX_DIM: set err=1, stay in IDLE.
    - Otherwise: clear err, latch n/m/q, go to LOAD_A.
  - LOAD_A: in_ready=1. Stores n*m elements at index i*MAX_DIM+k. After the last one, go to LOAD_B.
  - LOAD_B: in_ready=1. Stores m*q elements at index k*MAX_DIM+j. After the last one, set i=j=k=0 and go to MAC.
  - MAC: per cycle, acc += A[i][k]*B[k][j] as a full-precision signed product; acc is cleared when k=0. After k=m-1, go to EMIT the next cycle with out_data=fmt(acc).
  - EMIT: out_valid=1; out_last=1 iff i=n-1 && j=q-1. On handshake:
    - If last: go to IDLE.
    - Otherwise: advance j, wrapping to 0 and incrementing i; go to MAC.
- Latency: first out_valid comes m+1 cycles after the final B element is accepted. Each subsequent element takes m+1 cycles plus any backpressure stall.
- cfg_valid asserted while busy is ignored; cfg_ready=0.
- in_valid in IDLE, MAC or EMIT is ignored; in_ready=0.
- fmt(): takes the low DATA_WIDTH bits of acc (two's-complement wrap), unless SATURATE_EN is defined.
- n=m=q=1 is legal: 1 load cycle for A, 1 for B, 1 MAC cycle, then EMIT.

Optional Feature:
- Macro MATMUL_SATURATE_EN.
- Defined: fmt() clamps acc to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]. An extra output bit `sat` (registered with out_data) flags each clamped element.
- Undefined: plain truncation/wrap; no sat port.

Decomposition:
- Package matmul_pkg holds:
  - element_t (signed DATA_WIDTH)
  - acc_t (signed ACC_WIDTH)
  - dim_t
  - state enum {IDLE, LOAD_A, LOAD_B, MAC, EMIT}
  - function fmt_acc (wrap/saturate)
- Sub-module matmul_mac: clear/accumulate enable, signed multiply-add, registered acc. The FSM and buffer addressing stay in matmul_stream.

Test Plan:
- n=m=q=1, A=3, B=-2 -> single out_data=-6 with out_last=1; back to cfg_ready=1.
- 2x2x2, A=[1 2;3 4], B=[5 6;7 8] -> out 19,22,43,50 in order; out_last only on 50; first out_valid 3 cycles after last B.
- 2x3x2, A=[1 0 2;0 1 1], B=[1 2;3 4;5 6] -> out 11,14,8,10.
- cfg_n=0 or cfg_q=MAX_DIM+1 -> err=1, busy=0, in_ready never asserted. A following valid 1x1x1 job clears err.
- n=1, m=2, q=1, A=[32767 32767], B=[2;2] (acc=131068) -> out -4 without the macro; out 32767 with sat=1 when MATMUL_SATURATE_EN is defined.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles on the 2x2x2 job -> out_data stays at 19, no element lost.
  - Pull reset low during LOAD_B -> all outputs at reset values; a new job then runs correctly.
